// File: rtl/rld_rrd_unit_if.sv
// Bus bundle for rld_rrd_unit: CPU request/result signals plus the data-memory request/ack port.
interface rld_rrd_unit_if;
    logic        start;
    logic        dir;
    logic [7:0]  acc_in;
    logic [15:0] hl_in;
    logic        c_in;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [7:0]  acc_out;
    logic        acc_we;
    logic [7:0]  flags;
    logic        flags_we;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  start, dir, acc_in, hl_in, c_in, mem_rdata, mem_ack,
        output mem_addr, mem_rd, mem_wr, mem_wdata, acc_out, acc_we, flags, flags_we, busy, done, err
    );

    modport slave (
        output start, dir, acc_in, hl_in, c_in, mem_rdata, mem_ack,
        input  mem_addr, mem_rd, mem_wr, mem_wdata, acc_out, acc_we, flags, flags_we, busy, done, err
    );
endinterface

// File: rtl/rld_rrd_unit.sv
// Z80 RLD/RRD read-modify-write engine; start->done 4 cycles plus ack waits, start ignored while busy.
// Optional ack-wait timeout with err pulse when RLDRRD_ACK_TIMEOUT_EN is defined.
module rld_rrd_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    rld_rrd_unit_if.master     bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        dir_q;
    logic        c_q;
    logic [7:0]  acc_q;
    logic [15:0] addr_q;
    logic [7:0]  m_q;
    logic [7:0]  mnew_q;
    logic [7:0]  anew_q;
    logic [7:0]  fnew_q;
    logic [7:0]  acc_out_q;
    logic [7:0]  flags_q;

    logic [7:0]  mnew;
    logic [7:0]  anew;
    logic [7:0]  fnew;
    logic        tout;

    always_comb begin
        mnew = 8'h00;
        anew = 8'h00;
        if (dir_q) begin
            mnew = {acc_q[3:0], m_q[7:4]};
            anew = {acc_q[7:4], m_q[3:0]};
        end else begin
            mnew = {m_q[3:0], acc_q[3:0]};
            anew = {acc_q[7:4], m_q[7:4]};
        end
        // {S,Z,F5,H,F3,PV,N,C}; PV is set for even parity
        fnew = {anew[7], (anew == 8'h00), anew[5], 1'b0, anew[3], ~^anew, 1'b0, c_q};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_READ;
            S_READ: begin
                if (bus.mem_ack)  state_nxt = S_CALC;
                else if (tout)    state_nxt = S_IDLE;
            end
            S_CALC:  state_nxt = S_WRITE;
            S_WRITE: begin
                if (bus.mem_ack)  state_nxt = S_DONE;
                else if (tout)    state_nxt = S_IDLE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            dir_q     <= 1'b0;
            c_q       <= 1'b0;
            acc_q     <= 8'h00;
            addr_q    <= 16'h0000;
            m_q       <= 8'h00;
            mnew_q    <= 8'h00;
            anew_q    <= 8'h00;
            fnew_q    <= 8'h00;
            acc_out_q <= 8'h00;
            flags_q   <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.start) begin
                dir_q  <= bus.dir;
                acc_q  <= bus.acc_in;
                addr_q <= bus.hl_in;
                c_q    <= bus.c_in;
            end
            if (state == S_READ && bus.mem_ack) m_q <= bus.mem_rdata;
            if (state == S_CALC) begin
                mnew_q <= mnew;
                anew_q <= anew;
                fnew_q <= fnew;
            end
            // Architectural results only change on entry to DONE, so a timeout leaves them intact
            if (state == S_WRITE && bus.mem_ack) begin
                acc_out_q <= anew_q;
                flags_q   <= fnew_q;
            end
        end
    end

`ifdef RLDRRD_ACK_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    assign tout = (({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= ((state == S_READ || state == S_WRITE) && state_nxt == state)
                        ? wait_cnt + 8'd1 : 8'h00;
            err_q    <= (state == S_READ || state == S_WRITE) && !bus.mem_ack && tout;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign tout           = 1'b0;
    assign bus.err        = 1'b0;
`endif

    assign bus.mem_addr  = addr_q;
    assign bus.mem_rd    = (state == S_READ);
    assign bus.mem_wr    = (state == S_WRITE);
    assign bus.mem_wdata = mnew_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.flags     = flags_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.acc_we    = (state == S_DONE);
    assign bus.flags_we  = (state == S_DONE);

endmodule

// File: tb/tb_rld_rrd_unit.sv
// Self-checking bench for rld_rrd_unit: vector table, ack-wait/stray-input, mid-write reset and timeout sequences.
module tb_rld_rrd_unit;

    typedef struct {
        logic        dir;
        logic [7:0]  a;
        logic [7:0]  m;
        logic        c;
        logic [15:0] hl;
        int          rw;
        int          ww;
        logic [7:0]  wdata;
        logic [7:0]  acc;
        logic [7:0]  flg;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    rld_rrd_unit_if bus();

    rld_rrd_unit #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         rd_wait   = 0;
    int         wr_wait   = 0;
    int         rd_cnt    = 0;
    int         wr_cnt    = 0;
    logic [7:0] mem_byte  = 8'h00;
    bit         stray_ack = 1'b0;

    vec_t       sb[$];
    logic [7:0] wq[$];
    vec_t       vt[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after the configured number of wait cycles
    always @(negedge clk) begin
        logic [7:0] ew;
        if (bus.mem_rd || bus.mem_wr)
            check("rd_wr_exclusive", {31'd0, bus.mem_rd & bus.mem_wr}, 32'd0);
        if (bus.mem_rd) begin
            if (rd_cnt == rd_wait) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_byte;
                rd_cnt        = 0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 8'($urandom);
                rd_cnt++;
            end
        end else if (bus.mem_wr) begin
            if (wr_cnt == wr_wait) begin
                bus.mem_ack = 1'b1;
                wr_cnt      = 0;
                check("wq_nonempty", {31'd0, wq.size() != 0}, 32'd1);
                if (wq.size() != 0) begin
                    ew = wq.pop_front();
                    check("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, ew});
                end
            end else begin
                bus.mem_ack = 1'b0;
                wr_cnt++;
            end
        end else begin
            bus.mem_ack = stray_ack;
            rd_cnt      = 0;
            wr_cnt      = 0;
        end
    end

    task automatic run_op(input vec_t v, input int stray_cyc, input bit stray_ack_en);
        vec_t e;
        bit   got;
        sb.push_back(v);
        wq.push_back(v.wdata);
        rd_wait   = v.rw;
        wr_wait   = v.ww;
        mem_byte  = v.m;
        stray_ack = stray_ack_en;
        bus.start  = 1'b1;
        bus.dir    = v.dir;
        bus.acc_in = v.a;
        bus.hl_in  = v.hl;
        bus.c_in   = v.c;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.dir    = ~v.dir;
        bus.acc_in = 8'($urandom);
        bus.hl_in  = 16'($urandom);
        bus.c_in   = ~v.c;
        got = 1'b0;
        e   = v;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            bus.start = (cyc == stray_cyc);
            @(negedge clk);
            if (cyc == 1) begin
                check("mem_rd_cycle1", {31'd0, bus.mem_rd}, 32'd1);
                check("mem_addr", {16'd0, bus.mem_addr}, {16'd0, v.hl});
            end
            check("busy", {31'd0, bus.busy}, 32'd1);
            if (bus.done) begin
                got = 1'b1;
                check("latency", cyc, 4 + v.rw + v.ww);
                check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) e = sb.pop_front();
                check("acc_out", {24'd0, bus.acc_out}, {24'd0, e.acc});
                check("flags", {24'd0, bus.flags}, {24'd0, e.flg});
                check("strobes", {30'd0, bus.acc_we, bus.flags_we}, 32'd3);
                check("err_on_done", {31'd0, bus.err}, 32'd0);
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("done_seen", {31'd0, got}, 32'd1);
        if (got) begin
            @(negedge clk);
            check("idle_after_done", {28'd0, bus.busy, bus.done, bus.acc_we, bus.flags_we}, 32'd0);
            check("acc_hold", {24'd0, bus.acc_out}, {24'd0, e.acc});
            check("flags_hold", {24'd0, bus.flags}, {24'd0, e.flg});
            @(posedge clk); #1;
        end
        stray_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    initial begin
        bit got;
        //        dir   a      m      c     hl        rw ww wdata  acc    flg
        vt[0] = '{1'b0, 8'h7A, 8'h31, 1'b1, 16'h1234, 0, 0, 8'h1A, 8'h73, 8'h21};
        vt[1] = '{1'b1, 8'h84, 8'h20, 1'b0, 16'hBEEF, 0, 0, 8'h42, 8'h80, 8'h80};
        vt[2] = '{1'b0, 8'h05, 8'h0C, 1'b0, 16'h0000, 0, 0, 8'hC5, 8'h00, 8'h44};
        vt[3] = '{1'b1, 8'hF3, 8'h9C, 1'b1, 16'hFFFF, 1, 0, 8'h39, 8'hFC, 8'hAD};
        vt[4] = '{1'b0, 8'h40, 8'hE7, 1'b0, 16'h8001, 1, 1, 8'h70, 8'h4E, 8'h0C};

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.dir    = 1'b0;
        bus.acc_in = 8'h00;
        bus.hl_in  = 16'h0000;
        bus.c_in   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {25'd0, bus.busy, bus.done, bus.acc_we, bus.flags_we, bus.err, bus.mem_rd, bus.mem_wr}, 32'd0);
        check("rst_addr", {16'd0, bus.mem_addr}, 32'd0);
        check("rst_data", {8'd0, bus.mem_wdata, bus.acc_out, bus.flags}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_op(vt[i], 0, 1'b0);

        // Ack waits 3/2, a start pulse while busy and spurious acks outside READ/WRITE
        begin
            vec_t w;
            w    = vt[0];
            w.rw = 3;
            w.ww = 2;
            run_op(w, 2, 1'b1);
        end

        // Reset while a write is outstanding
        rd_wait    = 0;
        wr_wait    = 50;
        mem_byte   = 8'h31;
        bus.start  = 1'b1;
        bus.dir    = 1'b1;
        bus.acc_in = 8'hC3;
        bus.hl_in  = 16'h5A5A;
        bus.c_in   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.mem_wr) got = 1'b1;
        end
        check("reach_write", {31'd0, got}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstw_ctl", {25'd0, bus.busy, bus.done, bus.acc_we, bus.flags_we, bus.err, bus.mem_rd, bus.mem_wr}, 32'd0);
        check("rstw_addr", {16'd0, bus.mem_addr}, 32'd0);
        check("rstw_data", {8'd0, bus.mem_wdata, bus.acc_out, bus.flags}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(vt[0], 0, 1'b0);

`ifdef RLDRRD_ACK_TIMEOUT_EN
        rd_wait    = 1000;
        bus.start  = 1'b1;
        bus.dir    = 1'b1;
        bus.acc_in = 8'h11;
        bus.hl_in  = 16'h2222;
        bus.c_in   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc < 5) begin
                check("to_wait_err", {31'd0, bus.err}, 32'd0);
                check("to_wait_rd", {31'd0, bus.mem_rd}, 32'd1);
            end else if (cyc == 5) begin
                check("to_err", {31'd0, bus.err}, 32'd1);
                check("to_rd_drop", {30'd0, bus.mem_rd, bus.busy}, 32'd0);
            end else begin
                check("to_err_pulse", {31'd0, bus.err}, 32'd0);
                check("to_idle", {31'd0, bus.busy}, 32'd0);
            end
            check("to_no_done", {29'd0, bus.done, bus.acc_we, bus.flags_we}, 32'd0);
            @(posedge clk); #1;
        end
        check("to_acc_hold", {24'd0, bus.acc_out}, {24'd0, vt[0].acc});
        rd_wait = 0;
`endif

        check("sb_empty", sb.size(), 0);
        check("wq_empty", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rld_rrd_unit.md
# rld_rrd_unit

Multi-cycle nibble-rotate engine for the Z80-compatible core. It executes RLD and RRD as a memory read-modify-write sequence: read the byte at (HL), split and recombine its nibbles with the accumulator low nibble, write the byte back, then return the new accumulator and flags. It sits beside the single-cycle bit/nibble ALU and issues requests on the CPU data-memory port through a request/ack handshake. It is the split-and-redistribute counterpart of that ALU's nibble-merge operation.

## Interface
Parameters:
- TIMEOUT, 255: ack-wait limit in cycles. Used only when the timeout feature is compiled in.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- dir  in  1  0 = RLD, 1 = RRD; latched on start.
- acc_in  in  8  accumulator; latched on start.
- hl_in  in  16  memory address; latched on start.
- c_in  in  1  current carry flag; latched on start.
- mem_addr  out  16  memory address; equals the latched HL.
- mem_rd  out  1  read request; high throughout READ.
- mem_wr  out  1  write request; high throughout WRITE.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data; valid in the cycle mem_ack is high during READ.
- mem_ack  in  1  request completion.
- acc_out  out  8  new accumulator.
- acc_we  out  1  one-cycle accumulator write strobe.
- flags  out  8  {S,Z,F5,H,F3,PV,N,C}.
- flags_we  out  1  one-cycle flag write strobe.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse.

## Operation
State machine: IDLE, READ, CALC, WRITE, DONE.
- **IDLE**
  - start=1: latch dir, acc_in, hl_in, c_in, then go to READ.
  - start=0: stay in IDLE.
- **READ**
  - mem_rd=1.
  - On mem_ack: capture mem_rdata into M, then go to CALC.
  - Without mem_ack: hold in READ.
- **CALC** (1 cycle)
  - RLD: Mnew = {M[3:0], A[3:0]}, Anew = {A[7:4], M[7:4]}.
  - RRD: Mnew = {A[3:0], M[7:4]}, Anew = {A[7:4], M[3:0]}.
  - Register Mnew, Anew and flags, then go to WRITE.
- **WRITE**
  - mem_wr=1, mem_wdata=Mnew.
  - On mem_ack: go to DONE.
- **DONE** (1 cycle)
  - done=1, acc_we=1, flags_we=1, acc_out=Anew.
  - Then go to IDLE.
- **Flags**
  - S=Anew[7]; Z=(Anew==0); F5=Anew[5]; H=0; F3=Anew[3]; N=0; C=latched c_in.
  - PV=1 when Anew has even parity.
- **Handshake rules**
  - start is ignored when not in IDLE.
  - mem_ack is ignored in IDLE, CALC and DONE.
  - mem_rd and mem_wr are never high together.
  - Requests are driven from registered state only.
- **Reset** (any time, including mid-WRITE)
  - State goes to IDLE immediately.
  - All outputs go to 0: mem_addr, mem_wdata, acc_out and flags read 0x0000/0x00; every strobe, busy and err read 0.
  - A partially issued write is abandoned. The memory side must tolerate a dropped mem_wr.

## Timing
- Start is sampled at edge 0. mem_rd is high from cycle 1.
- With a zero-wait ack, which may arrive in the first cycle of the request:
  - READ: cycle 1.
  - CALC: cycle 2.
  - WRITE: cycle 3.
  - DONE: cycle 4.
  - IDLE: cycle 5.
- Minimum latency: 4 cycles from start to done. Each cycle of ack wait adds one cycle.
- The next start is accepted in cycle 5 at the earliest.
- busy is high for cycles 1 through 4.
- acc_out and flags hold their values until the next DONE.

## Configuration
- RLDRRD_ACK_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to READ or WRITE and increments each cycle without ack.
  - When the count reaches TIMEOUT: pulse err for 1 cycle, deassert the request, return to IDLE. No acc_we, flags_we or done is issued.
- Not defined:
  - READ and WRITE wait for ack indefinitely.
  - err is tied to 0.
  - No counter logic is generated.

## Test plan
- **RLD with carry:** RLD, A=0x7A, mem=0x31, c_in=1, zero-wait ack.
  - Memory is written with 0x1A.
  - acc_out=0x73, flags=0x21.
  - done is high in cycle 4.
- **RRD without carry:** RRD, A=0x84, mem=0x20, c_in=0.
  - Memory is written with 0x42.
  - acc_out=0x80, flags=0x80.
- **Zero result:** RLD, A=0x05, mem=0x0C, c_in=0.
  - Memory is written with 0xC5.
  - acc_out=0x00, flags=0x44 (Z=1, PV=1).
- **Ack wait states and stray inputs:** read ack delayed 3 cycles, write ack delayed 2 cycles.
  - done is high in cycle 9.
  - A start pulsed during busy is ignored.
  - A spurious mem_ack in CALC has no effect.
- **Reset mid-WRITE:** assert reset while in WRITE.
  - mem_wr, busy and all strobes drop asynchronously.
  - After reset release, a new start behaves as in the first scenario.
- **Timeout** (RLDRRD_ACK_TIMEOUT_EN, TIMEOUT=4): no read ack.
  - err pulses in cycle 5 and mem_rd drops.
  - No done, acc_we or flags_we is issued.
  - State returns to IDLE.
